// File: rtl/act_word_feeder_pkg.sv
// Shared definitions for the activation word feeder: FSM encodings and the
// elaboration-time geometry check used by the top.
package act_word_feeder_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // A word must split exactly into ROWS lanes; DEPTH must be a power of two >= 2.
  function automatic bit cfg_ok(input int rows, input int data_w,
                                input int word_w, input int depth);
    return (rows * data_w == word_w) && (rows >= 2) &&
           (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/act_word_feeder_sync_fifo.sv
// Single-clock FIFO with full/empty/level; a push into a full FIFO is taken
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/act_word_feeder.sv
// West-edge activation feeder: buffers words, unpacks them into ROWS lanes and
// skews row r by r cycles. Optional FEEDER_STATS_EN adds a bubble counter port.
module act_word_feeder
  import act_word_feeder_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int DATA_W = 8,
  parameter int ROWS   = 4,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WORD_W-1:0]          in_data,
  input  logic                       in_valid,
  input  logic                       start,
  input  logic [CNT_W-1:0]           vec_count,
  output logic [ROWS*DATA_W-1:0]     a_out,
  output logic [ROWS-1:0]            a_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     fifo_level
`ifdef FEEDER_STATS_EN
  ,
  output logic [15:0]                bubble_cnt
`endif
);

  localparam int DC_W = $clog2(ROWS) + 1;

  if (!cfg_ok(ROWS, DATA_W, WORD_W, DEPTH)) begin : g_bad_cfg
    $error("act_word_feeder: need ROWS*DATA_W == WORD_W, ROWS >= 2, DEPTH power of two >= 2");
  end

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  remaining;
  logic [DC_W-1:0]   dcnt;
  logic [WORD_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              start_acc;
  logic              pop;
  logic              last_pop;
  logic              drain_end;
  logic              drop;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign start_acc = start && !busy && (state == S_IDLE);
  assign pop       = (state == S_FEED) && !fifo_empty;
  assign last_pop  = pop && (remaining == CNT_W'(1));
  assign drain_end = (state == S_DRAIN) && (dcnt == DC_W'(ROWS - 1));
  assign drop      = in_valid && fifo_full && !pop;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_acc) state_nxt = (vec_count == '0) ? S_DRAIN : S_FEED;
      S_FEED:  if (last_pop)  state_nxt = S_DRAIN;
      S_DRAIN: if (drain_end) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control: state, run counters, status flags.
  // DRAIN is entered at dcnt=1 after the last pop so done lands ROWS cycles
  // after that pop; a zero-length run enters at the final count instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      remaining <= '0;
      dcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= drain_end;
      if (start_acc)      remaining <= vec_count;
      else if (pop)       remaining <= remaining - CNT_W'(1);
      if (start_acc && vec_count == '0) dcnt <= DC_W'(ROWS - 1);
      else if (last_pop)                dcnt <= DC_W'(1);
      else if (state == S_DRAIN)        dcnt <= dcnt + DC_W'(1);
      if (start_acc)      busy <= 1'b1;
      else if (drain_end) busy <= 1'b0;
      if (drop)           overflow <= 1'b1;
      else if (start_acc) overflow <= 1'b0;
    end
  end

  // Skew stage: row r is the popped lane r delayed by r+1 registers.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATA_W-1:0] pipe_d [r+1];
    logic              pipe_v [r+1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= r; k++) begin
          pipe_d[k] <= '0;
          pipe_v[k] <= 1'b0;
        end
      end else begin
        pipe_d[0] <= pop ? fifo_rdata[r*DATA_W +: DATA_W] : '0;
        pipe_v[0] <= pop;
        for (int k = 1; k <= r; k++) begin
          pipe_d[k] <= pipe_d[k-1];
          pipe_v[k] <= pipe_v[k-1];
        end
      end
    end

    assign a_out[r*DATA_W +: DATA_W] = pipe_d[r];
    assign a_valid[r]                = pipe_v[r];
  end

`ifdef FEEDER_STATS_EN
  logic bubble;
  assign bubble = (state == S_FEED) && fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            bubble_cnt <= '0;
    else if (start_acc)                    bubble_cnt <= '0;
    else if (bubble && bubble_cnt != '1)   bubble_cnt <= bubble_cnt + 16'd1;
  end
`endif

endmodule
